// File: rtl/t05_bit_packer_pkg.sv
// t05 bit packer shared types.
// Packer FSM states, byte/counter widths and a pad helper.
package t05_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    PACK,
    FLUSH,
    DRAIN
  } pk_state_t;

  // Move the low `fill` bits of a partial byte to the top, zero LSBs.
  function automatic logic [BYTE_W-1:0] left_align(
    input logic [BYTE_W-1:0] sr,
    input logic [2:0]        fill
  );
    return sr << (3'd0 - fill);
  endfunction

endpackage

// File: rtl/t05_bit_packer_if.sv
// t05 bit packer bus.
// Bit-in and byte-out handshakes plus flush/status signals.
interface t05_bit_packer_if;
  import t05_pkg::*;

  logic               bit_valid;
  logic               bit_in;
  logic               bit_ready;
  logic               flush;
  logic               byte_valid;
  logic [BYTE_W-1:0]  byte_out;
  logic               byte_ready;
  logic               flush_done;
  logic [2:0]         pad_bits;
  logic [COUNT_W-1:0] byte_count;
  logic [COUNT_W-1:0] bit_count;

  modport master (
    output bit_valid, bit_in, flush, byte_ready,
    input  bit_ready, byte_valid, byte_out,
    input  flush_done, pad_bits, byte_count, bit_count
  );

  modport slave (
    input  bit_valid, bit_in, flush, byte_ready,
    output bit_ready, byte_valid, byte_out,
    output flush_done, pad_bits, byte_count, bit_count
  );

endinterface

// File: rtl/t05_byte_fifo.sv
// t05 byte FIFO, show-ahead, power-of-two depth.
// Head reads as zero while empty.
module t05_byte_fifo
  import t05_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign head    = empty ? '0 : mem[rptr];

  // Storage write; contents need no reset, head is masked.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally; occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/t05_bit_packer.sv
// t05 bit packer: MSB-first bit-to-byte packing with flush/pad.
// Macro T05_PACKER_BITCOUNT_EN enables the accepted-bit counter.
module t05_bit_packer
  import t05_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  t05_bit_packer_if.slave bus
);

  pk_state_t          state;
  logic [BYTE_W-1:0]  sr;
  logic [2:0]         fill;
  logic               live;
  logic [2:0]         pad_q;
  logic [COUNT_W-1:0] byte_cnt;
  logic [BYTE_W-1:0]  shifted;
  logic [BYTE_W-1:0]  push_byte;
  logic               push;
  logic               pop;
  logic               accept;
  logic               full;
  logic               empty;

  t05_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_byte),
    .pop   (pop),
    .head  (bus.byte_out),
    .full  (full),
    .empty (empty)
  );

  assign shifted        = {sr[BYTE_W-2:0], bus.bit_in};
  assign bus.bit_ready  = live && state == PACK && !full;
  assign accept         = bus.bit_valid && bus.bit_ready;
  assign pop            = !empty && bus.byte_ready;
  assign bus.byte_valid = !empty;
  assign bus.flush_done = state == DRAIN && empty;
  assign bus.pad_bits   = pad_q;
  assign bus.byte_count = byte_cnt;

  // Push a completed byte, or the padded partial while flushing.
  always_comb begin
    push      = 1'b0;
    push_byte = shifted;
    unique case (1'b1)
      accept && fill == 3'd7: push = 1'b1;
      state == FLUSH && fill != 3'd0 && !full: begin
        push      = 1'b1;
        push_byte = left_align(sr, fill);
      end
      default: ;
    endcase
  end

  // Packer FSM; a bit taken with flush is packed before padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PACK;
      sr    <= '0;
      fill  <= '0;
      live  <= 1'b0;
      pad_q <= '0;
    end else begin
      live <= 1'b1;
      unique case (state)
        PACK: begin
          if (accept) begin
            sr   <= shifted;
            fill <= fill + 1'b1;
          end
          if (bus.flush) state <= FLUSH;
        end
        FLUSH: begin
          if (fill == 3'd0) begin
            pad_q <= '0;
            state <= DRAIN;
          end else if (!full) begin
            pad_q <= 3'd0 - fill;
            fill  <= '0;
            sr    <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) state <= PACK;
        end
        default: state <= PACK;
      endcase
    end
  end

  // Bytes handed to the SPI writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_cnt <= '0;
    else if (pop) byte_cnt <= byte_cnt + 1'b1;
  end

`ifdef T05_PACKER_BITCOUNT_EN
  logic [COUNT_W-1:0] bit_cnt;

  // Accepted-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_cnt <= '0;
    else if (accept) bit_cnt <= bit_cnt + 1'b1;
  end

  assign bus.bit_count = bit_cnt;
`else
  assign bus.bit_count = '0;
`endif

endmodule

// File: tb/tb_t05_bit_packer.sv
// t05 bit packer bench: queue model plus scoreboard monitor.
// Directed scenarios followed by random bits/flush/backpressure.
module tb_t05_bit_packer;
  import t05_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  t05_bit_packer_if bus ();

  t05_bit_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q [$];
  logic       bits [$];
  int         model_bits;
  int         pops;
  logic       flushing;
  int         exp_pad;
  logic       armed;
  logic       rand_ready = 1'b0;
  logic       ready_force = 1'b0;
  int         sent;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [7:0] pack_bits();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < bits.size(); i++) v[7-i] = bits[i];
    return v;
  endfunction

  // Reference: ready rises one edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else armed <= 1'b1;
  end

  // Sink backpressure.
  always @(posedge clk) begin
    #1;
    bus.byte_ready = rand_ready ? 1'($urandom_range(0, 1))
                                : ready_force;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bits.delete();
      model_bits = 0;
      pops = 0;
      flushing = 1'b0;
      exp_pad = 0;
    end else begin
      chk("byte_count", bus.byte_count, pops);
`ifdef T05_PACKER_BITCOUNT_EN
      chk("bit_count", bus.bit_count, model_bits);
`else
      chk("bit_count", bus.bit_count, 0);
`endif
      chk("bit_ready", 32'(bus.bit_ready),
          32'(armed && !flushing && exp_q.size() < DEPTH));
      if (!flushing)
        chk("byte_valid", 32'(bus.byte_valid),
            32'(exp_q.size() != 0));
      if (bus.byte_valid) begin
        if (exp_q.size() == 0) fail("byte_unexpected");
        else begin
          chk("byte_out", bus.byte_out, exp_q[0]);
          if (bus.byte_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (bus.bit_valid && bus.bit_ready) begin
        bits.push_back(bus.bit_in);
        model_bits++;
        if (bits.size() == 8) begin
          exp_q.push_back(pack_bits());
          bits.delete();
        end
      end
      if (bus.flush && !flushing) begin
        flushing = 1'b1;
        exp_pad = bits.size() == 0 ? 0 : 8 - bits.size();
        if (bits.size() != 0) exp_q.push_back(pack_bits());
        bits.delete();
      end else if (bus.flush_done) begin
        if (!flushing) fail("flush_done_spurious");
        else begin
          chk("pad_bits", bus.pad_bits, exp_pad);
          chk("drained", exp_q.size(), 0);
          flushing = 1'b0;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic fl);
    logic acc;
    acc = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in = b;
    bus.flush = fl;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.bit_ready;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
    end
    bus.bit_valid = 1'b0;
    if (acc) sent++;
    else fail("bit_timeout");
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic send_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.flush_done) seen = 1'b1;
      else cyc++;
    end
    if (!seen) fail("flush_timeout");
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int r;
    logic [7:0] b2;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.flush = 1'b0;
    ready_force = 1'b1;
    sent = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit_ready", 32'(bus.bit_ready), 0);
    chk("rst_byte_valid", 32'(bus.byte_valid), 0);
    chk("rst_byte_out", bus.byte_out, 0);
    chk("rst_flush_done", 32'(bus.flush_done), 0);
    chk("rst_pad", bus.pad_bits, 0);
    chk("rst_byte_count", bus.byte_count, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 32'(bus.bit_ready), 0);
    settle();
    chk("ready_after_edge", 32'(bus.bit_ready), 1);

    b2 = 8'hB2;
    send_byte(b2);
    chk("b2_valid", 32'(bus.byte_valid), 1);
    chk("b2_byte", bus.byte_out, 8'hB2);
    settle();
    chk("b2_count", bus.byte_count, 1);

    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_flush();
    wait_done(cyc);
    chk("e0_pad", bus.pad_bits, 5);
    chk("e0_count", bus.byte_count, 2);
`ifdef T05_PACKER_BITCOUNT_EN
    chk("e0_bit_count", bus.bit_count, 11);
`else
    chk("e0_bit_count", bus.bit_count, 0);
`endif
    settle();

    send_flush();
    wait_done(cyc);
    chk("flush0_latency", 32'(cyc <= 2), 1);
    chk("flush0_pad", bus.pad_bits, 0);
    chk("flush0_count", bus.byte_count, 2);
    settle();

    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_bit(1'b1, 1'b1);
    wait_done(cyc);
    chk("flush8_pad", bus.pad_bits, 0);
    chk("flush8_count", bus.byte_count, 3);
    settle();

    ready_force = 1'b0;
    settle();
    settle();
    sent = 0;
    fork
      begin
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
      end
      begin
        repeat (45) @(posedge clk);
        #1;
        chk("stall_bits", sent, 32);
        chk("stall_ready", 32'(bus.bit_ready), 0);
        chk("stall_valid", 32'(bus.byte_valid), 1);
        chk("stall_head", bus.byte_out, 8'h11);
        ready_force = 1'b1;
      end
    join
    repeat (15) settle();
    chk("stall_count", bus.byte_count, 8);

    ready_force = 1'b0;
    settle();
    settle();
    for (int i = 0; i < 21; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.byte_valid), 0);
    chk("midrst_ready", 32'(bus.bit_ready), 0);
    chk("midrst_count", bus.byte_count, 0);
    ready_force = 1'b1;
    settle();
    settle();
    rst_n = 1'b1;
    send_byte(8'hFF);
    repeat (3) settle();
    chk("postrst_count", bus.byte_count, 1);

    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        send_flush();
        wait_done(cyc);
        settle();
      end else if (r < 20) begin
        settle();
      end else begin
        send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    send_flush();
    wait_done(cyc);
    settle();
    rand_ready = 1'b0;
    repeat (3) settle();
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
